mouse_uart_fmt: RTL
===================

Name: mouse_uart_fmt

Overview:
Upstream feeder for the UART transmit FIFO in the PS/2 mouse design. Latches each decoded mouse packet and serialises it into a fixed-length ASCII text line. It writes the line one character per cycle into the UART TX FIFO through its write/full handshake. It holds one pending packet while a line is in progress and counts packets dropped on overrun.

Parameters:
HEX_UPPER, 1, 1 = hex digits A-F emitted uppercase (0x41..0x46); 0 = lowercase (0x61..0x66)
EOL_CRLF, 1, 1 = line ends CR LF (13-char frame); 0 = LF only (12-char frame)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
m_done_tick  in  1  one-cycle strobe: new mouse packet valid on btnm/xm/ym
btnm  in  3  buttons: [0]=left, [1]=right, [2]=middle
xm  in  9  X movement, two's complement
ym  in  9  Y movement, two's complement
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  FIFO write strobe; one character per asserted cycle
w_data  out  8  ASCII character, valid when wr_uart=1
busy  out  1  frame in progress (state SEND)
drop_cnt  out  8  packets lost to overrun, saturates at 0xFF

Behaviour:
- Reset (reset=0, async): state IDLE, char_idx=0, pend_vld=0, drop_cnt=0, busy=0. wr_uart=0 and w_data=0x00.
- Frame, char_idx 0..N-1:
  - 0: 'L' if btnm[0], else '-'
  - 1: 'M' if btnm[2], else '-'
  - 2: 'R' if btnm[1], else '-'
  - 3: ' '
  - 4..6: xm as 3 hex digits, MSB first; digit 4 = {3'b0, xm[8]}
  - 7: ' '
  - 8..10: ym, same encoding
  - 11: CR (0x0D), 12: LF (0x0A) when EOL_CRLF=1
  - 11: LF when EOL_CRLF=0
- N = 13 or 12.
- Registers:
  - active packet (btn, x, y) latched from inputs.
  - pending packet + pend_vld.
- FSM IDLE:
  - m_done_tick: latch inputs into active, char_idx=0, go SEND next cycle.
  - Otherwise hold.
- FSM SEND:
  - wr_uart = !tx_full (combinational from tx_full and state); w_data = char(char_idx).
  - On a write, char_idx++.
  - On a write at char_idx=N-1:
    - pend_vld=1: copy pending to active, pend_vld=0, char_idx=0, stay SEND.
    - m_done_tick in same cycle with pend_vld=0: latch inputs directly into active, stay SEND.
    - Otherwise go IDLE.
  - tx_full=1: stall. wr_uart=0, char_idx and active unchanged, no timeout.
- Packet arrival while busy (not consumed by the end-of-frame rule):
  - pend_vld=0: store in pending, pend_vld=1.
  - pend_vld=1: discard the new packet (pending keeps the older one); drop_cnt++ saturating at 0xFF.
- Latency:
  - Tick in IDLE at cycle t → first character written at t+1 if tx_full=0.
  - Unstalled frame occupies N consecutive cycles.
- busy = (state==SEND), registered.
- Reset mid-frame aborts immediately. Partial line already in the FIFO is not retracted.
- w_data is 0x00 whenever wr_uart=0.

Decomposition:
- Package mouse_uart_pkg:
  - ASCII constants: SPACE, DASH, CR, LF, 'L', 'M', 'R', '0', 'A', 'a'
  - FRAME_LEN_CRLF=13, FRAME_LEN_LF=12
  - state encoding IDLE/SEND
- One sub-module, hex_to_ascii: combinational 4-bit nibble → ASCII digit, parameter HEX_UPPER; instantiated once, fed by char_idx-selected nibble.

Test Plan:
- btnm=3'b101, xm=9'h1F3, ym=9'h005, single tick, tx_full=0 → 13 consecutive writes starting next cycle: "LM- 1F3 005" 0x0D 0x0A; busy=1 for 13 cycles, then 0.
- Same packet, tx_full held 1 for 5 cycles after the 4th character → wr_uart=0 during the stall, no characters lost or repeated, byte stream identical to the unstalled case.
- Three ticks 2 cycles apart (packets A, B, C) → frames A then B back-to-back with no IDLE gap; C dropped; drop_cnt=1.
- Tick coincident with the LF write of the previous frame and pend_vld=0 → next cycle starts the new frame at char_idx 0; drop_cnt unchanged.
- HEX_UPPER=0, EOL_CRLF=0, xm=9'h0AB, ym=9'h1FF, btnm=0 → "--- 0ab 1ff" 0x0A, 12 writes.
- Assert reset at char_idx=6 with a pending packet → wr_uart=0, busy=0, drop_cnt=0 asynchronously. Next tick after release produces a complete fresh frame.

Source files
------------

// File: rtl/mouse_uart_fmt_pkg.sv
// Shared constants and types for the mouse packet to ASCII line formatter.
// Contents: ASCII character codes, frame lengths for both line endings,
// the formatter state encoding and the latched packet record.
package mouse_uart_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_LA    = 8'h61;

  localparam int FRAME_LEN_CRLF = 13;
  localparam int FRAME_LEN_LF   = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] btn;
    logic [8:0] x;
    logic [8:0] y;
  } pkt_t;

endpackage

// File: rtl/mouse_uart_fmt_hex_to_ascii.sv
// Combinational nibble to ASCII hex digit converter.
// Ports:
//   nibble : 4-bit value 0..15
//   ascii  : '0'..'9', then 'A'..'F' (HEX_UPPER=1) or 'a'..'f' (HEX_UPPER=0)
module hex_to_ascii
  import mouse_uart_pkg::*;
#(
  parameter int HEX_UPPER = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'd0, nibble};
    end else begin
      ascii = ((HEX_UPPER != 0) ? ASCII_UA : ASCII_LA) + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/mouse_uart_fmt.sv
// Mouse packet to ASCII text line formatter feeding the UART TX FIFO.
// Each packet becomes "BBB XXX YYY" + EOL, one character per unstalled cycle.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   m_done_tick     : one-cycle strobe, packet valid on btnm/xm/ym
//   btnm, xm, ym    : buttons {middle,right,left}, 9-bit two's complement X/Y
//   tx_full         : FIFO full, stalls the line
//   wr_uart, w_data : FIFO write strobe and character (0x00 when not writing)
//   busy            : line in progress; this is the state register itself
//   drop_cnt        : packets lost to overrun, saturating at 0xFF
// Handshake: a character is transferred in every cycle where wr_uart=1;
// wr_uart = busy & !tx_full, so the FIFO's full flag is the only back-pressure.
module mouse_uart_fmt
  import mouse_uart_pkg::*;
#(
  parameter int HEX_UPPER = 1,
  parameter int EOL_CRLF  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_done_tick,
  input  logic [2:0] btnm,
  input  logic [8:0] xm,
  input  logic [8:0] ym,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int         N        = (EOL_CRLF != 0) ? FRAME_LEN_CRLF : FRAME_LEN_LF;
  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  pkt_t       act_q, act_d;
  pkt_t       pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] drop_q, drop_d;

  pkt_t       in_pkt;
  logic       fire;
  logic       consumed;
  logic [3:0] nibble;
  logic [7:0] hex_char;
  logic [7:0] frame_char;

  assign in_pkt   = '{btn: btnm, x: xm, y: ym};
  assign fire     = (state_q == ST_SEND) && !tx_full;
  assign busy     = (state_q == ST_SEND);
  assign drop_cnt = drop_q;

  // State register plus the packet/index datapath it owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;
    consumed   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_done_tick) begin
          act_d   = in_pkt;
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            if (pend_vld_q) begin
              act_d      = pend_q;
              pend_vld_d = 1'b0;
            end else if (m_done_tick) begin
              // A packet arriving on the final character starts the next
              // line directly, without passing through the pending slot.
              act_d    = in_pkt;
              consumed = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        // Arrival judged against the slot as it was this cycle: a slot being
        // drained into the active line still counts as occupied.
        if (m_done_tick && !consumed) begin
          if (!pend_vld_q) begin
            pend_d     = in_pkt;
            pend_vld_d = 1'b1;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hex digit nibble for the current column; X sign bit forms its own digit.
  always_comb begin
    case (idx_q)
      4'd4:    nibble = {3'b000, act_q.x[8]};
      4'd5:    nibble = act_q.x[7:4];
      4'd6:    nibble = act_q.x[3:0];
      4'd8:    nibble = {3'b000, act_q.y[8]};
      4'd9:    nibble = act_q.y[7:4];
      4'd10:   nibble = act_q.y[3:0];
      default: nibble = 4'd0;
    endcase
  end

  hex_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_hex (
    .nibble(nibble),
    .ascii (hex_char)
  );

  always_comb begin
    case (idx_q)
      4'd0:    frame_char = act_q.btn[0] ? ASCII_L : ASCII_DASH;
      4'd1:    frame_char = act_q.btn[2] ? ASCII_M : ASCII_DASH;
      4'd2:    frame_char = act_q.btn[1] ? ASCII_R : ASCII_DASH;
      4'd3,
      4'd7:    frame_char = ASCII_SPACE;
      4'd4, 4'd5, 4'd6,
      4'd8, 4'd9, 4'd10:
               frame_char = hex_char;
      4'd11:   frame_char = (EOL_CRLF != 0) ? ASCII_CR : ASCII_LF;
      4'd12:   frame_char = ASCII_LF;
      default: frame_char = 8'h00;
    endcase
  end

  // Output logic.
  always_comb begin
    wr_uart = 1'b0;
    w_data  = 8'h00;
    if (fire) begin
      wr_uart = 1'b1;
      w_data  = frame_char;
    end
  end

endmodule
